// File: rtl/pe_mslot.sv
// pe_mslot: weight-stationary systolic MAC PE with a WGT_DEPTH-slot weight bank,
//   ID-matched daisy-chain loading and pop-driven slot rotation.
// Latency: load/right forward 1 cycle, pop-to-down 3 cycles; no stalls, no backpressure.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   i_load_vld/id/data                  load beat in from the previous PE
//   o_load_vld/id/data                  load beat out; a beat that was consumed here leaves with vld=0
//   o_wgt_rdy                           every weight slot has been written at least once
//   i_pop_vld, o_pop_vld                compute beat valid in; the same valid 3 cycles later
//   i_up_data, o_down_data              partial sum in from above, partial sum out to below
//   i_left_data, o_right_data           operand in from the left, operand out to the right
//
// Build option: define PE_MSLOT_SAT_EN to saturate the final sum instead of wrapping it.

module pe_mslot #(
  parameter int ID_VAL         = 0,
  parameter int ID_WIDTH       = 6,
  parameter int IN_DATA_WIDTH  = 8,
  parameter int OUT_DATA_WIDTH = 24,
  parameter int WGT_DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_load_vld,
  input  logic [ID_WIDTH-1:0]       i_load_id,
  input  logic [IN_DATA_WIDTH-1:0]  i_load_data,
  output logic                      o_load_vld,
  output logic [ID_WIDTH-1:0]       o_load_id,
  output logic [IN_DATA_WIDTH-1:0]  o_load_data,
  output logic                      o_wgt_rdy,
  input  logic                      i_pop_vld,
  output logic                      o_pop_vld,
  input  logic [OUT_DATA_WIDTH-1:0] i_up_data,
  input  logic [IN_DATA_WIDTH-1:0]  i_left_data,
  output logic [IN_DATA_WIDTH-1:0]  o_right_data,
  output logic [OUT_DATA_WIDTH-1:0] o_down_data
);

  localparam int PTR_W  = (WGT_DEPTH > 1) ? $clog2(WGT_DEPTH) : 1;
  localparam int PROD_W = 2 * IN_DATA_WIDTH;
  localparam int SUM_W  = OUT_DATA_WIDTH + 1;
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(WGT_DEPTH - 1);

  // Weight bank and rotation pointers
  logic signed [IN_DATA_WIDTH-1:0] r_wgt [WGT_DEPTH];
  logic [PTR_W-1:0] r_load_ptr;
  logic [PTR_W-1:0] r_pop_ptr;
  logic             r_wgt_rdy;

  // Load chain forward registers
  logic                     r_load_vld;
  logic [ID_WIDTH-1:0]      r_load_id;
  logic [IN_DATA_WIDTH-1:0] r_load_data;
  logic [IN_DATA_WIDTH-1:0] r_right_data;

  // Compute pipeline
  logic                             r_s1_vld;
  logic signed [IN_DATA_WIDTH-1:0]  r_s1_left;
  logic signed [IN_DATA_WIDTH-1:0]  r_s1_wgt;
  logic signed [OUT_DATA_WIDTH-1:0] r_s1_up;
  logic                             r_s2_vld;
  logic signed [PROD_W-1:0]         r_s2_prod;
  logic signed [OUT_DATA_WIDTH-1:0] r_s2_up;
  logic                             r_s3_vld;
  logic [OUT_DATA_WIDTH-1:0]        r_down_data;

  logic                             w_hit;
  logic [PTR_W-1:0]                 w_load_ptr_nxt;
  logic [PTR_W-1:0]                 w_pop_ptr_nxt;
  logic signed [IN_DATA_WIDTH-1:0]  w_sel_wgt;
  logic signed [SUM_W-1:0]          w_prod_ext;
  logic signed [SUM_W-1:0]          w_up_ext;
  logic signed [SUM_W-1:0]          w_sum;
  logic [OUT_DATA_WIDTH-1:0]        w_sum_out;

  assign w_hit          = i_load_vld && (i_load_id == ID_WIDTH'(ID_VAL));
  assign w_load_ptr_nxt = (r_load_ptr == LAST_SLOT) ? '0 : r_load_ptr + 1'b1;
  assign w_pop_ptr_nxt  = (r_pop_ptr  == LAST_SLOT) ? '0 : r_pop_ptr  + 1'b1;
  // Combinational read of the current bank contents: a same-cycle write to this
  // slot lands on the clock edge, so the pop sees the old weight.
  assign w_sel_wgt      = r_wgt[r_pop_ptr];

  // One extra bit of headroom so overflow of the final add is observable.
  assign w_prod_ext = {{(SUM_W - PROD_W){r_s2_prod[PROD_W-1]}}, r_s2_prod};
  assign w_up_ext   = {r_s2_up[OUT_DATA_WIDTH-1], r_s2_up};
  assign w_sum      = w_prod_ext + w_up_ext;

`ifdef PE_MSLOT_SAT_EN
  always_comb begin
    w_sum_out = w_sum[OUT_DATA_WIDTH-1:0];
    // Top two bits disagree only when the result left the OUT_DATA_WIDTH range.
    if (w_sum[SUM_W-1] != w_sum[SUM_W-2]) begin
      w_sum_out = w_sum[SUM_W-1] ? {1'b1, {(OUT_DATA_WIDTH-1){1'b0}}}
                                 : {1'b0, {(OUT_DATA_WIDTH-1){1'b1}}};
    end
  end
`else
  assign w_sum_out = w_sum[OUT_DATA_WIDTH-1:0];
`endif

  // Load path: bank write, pointer rotation, ready flag and chain forwarding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WGT_DEPTH; i++) r_wgt[i] <= '0;
      r_load_ptr  <= '0;
      r_wgt_rdy   <= 1'b0;
      r_load_vld  <= 1'b0;
      r_load_id   <= '0;
      r_load_data <= '0;
    end else begin
      if (w_hit) begin
        r_wgt[r_load_ptr] <= i_load_data;
        r_load_ptr        <= w_load_ptr_nxt;
        if (w_load_ptr_nxt == '0) r_wgt_rdy <= 1'b1;
      end
      r_load_vld  <= i_load_vld && !w_hit;
      r_load_id   <= i_load_id;
      r_load_data <= i_load_data;
    end
  end

  // Compute path: valids shift every cycle, data stages load only on their valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pop_ptr    <= '0;
      r_right_data <= '0;
      r_s1_vld     <= 1'b0;
      r_s1_left    <= '0;
      r_s1_wgt     <= '0;
      r_s1_up      <= '0;
      r_s2_vld     <= 1'b0;
      r_s2_prod    <= '0;
      r_s2_up      <= '0;
      r_s3_vld     <= 1'b0;
      r_down_data  <= '0;
    end else begin
      r_right_data <= i_left_data;
      r_s1_vld     <= i_pop_vld;
      r_s2_vld     <= r_s1_vld;
      r_s3_vld     <= r_s2_vld;
      if (i_pop_vld) begin
        r_s1_left <= i_left_data;
        r_s1_wgt  <= w_sel_wgt;
        r_s1_up   <= i_up_data;
        r_pop_ptr <= w_pop_ptr_nxt;
      end
      if (r_s1_vld) begin
        r_s2_prod <= r_s1_left * r_s1_wgt;
        r_s2_up   <= r_s1_up;
      end
      if (r_s2_vld) begin
        r_down_data <= w_sum_out;
      end
    end
  end

  assign o_load_vld   = r_load_vld;
  assign o_load_id    = r_load_id;
  assign o_load_data  = r_load_data;
  assign o_wgt_rdy    = r_wgt_rdy;
  assign o_pop_vld    = r_s3_vld;
  assign o_right_data = r_right_data;
  assign o_down_data  = r_down_data;

endmodule

// File: doc/pe_mslot.md
# pe_mslot

Multi-slot weight-stationary systolic processing element for the MAC array. Weights are captured from a daisy-chained load bus by ID match into a WGT_DEPTH-entry local bank. Each pop multiplies the left operand by the current bank slot and adds the partial sum from above. Left data is forwarded right, the result goes down, and unmatched load beats are forwarded to the next PE.

## Interface
- ID_VAL, 0: PE identifier matched on the load bus
- ID_WIDTH, 6: load ID width
- IN_DATA_WIDTH, 8: operand/weight width, signed two's complement
- OUT_DATA_WIDTH, 24: partial-sum width, signed; must be >= 2*IN_DATA_WIDTH
- WGT_DEPTH, 4: number of weight slots, >= 1
- Clock and reset (already decided): one clock `clk`; reset `rst_n` is asynchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_load_vld  in  1  load beat valid
- i_load_id  in  ID_WIDTH  load beat target ID
- i_load_data  in  IN_DATA_WIDTH  load beat weight
- o_load_vld  out  1  forwarded beat valid
- o_load_id  out  ID_WIDTH  forwarded ID
- o_load_data  out  IN_DATA_WIDTH  forwarded weight
- o_wgt_rdy  out  1  all WGT_DEPTH slots written since reset
- i_pop_vld  in  1  compute beat valid
- o_pop_vld  out  1  i_pop_vld delayed to align with o_down_data
- i_up_data  in  OUT_DATA_WIDTH  partial sum from above
- i_left_data  in  IN_DATA_WIDTH  operand from left
- o_right_data  out  IN_DATA_WIDTH  operand to right
- o_down_data  out  OUT_DATA_WIDTH  partial sum to below

## Operation
**Load path**
- hit = i_load_vld && i_load_id == ID_VAL.
- On hit, write wgt[load_ptr] <= i_load_data and increment load_ptr, wrapping from WGT_DEPTH-1 to 0.
- Writes after a wrap overwrite earlier slots.
- Every cycle, o_load_id/o_load_data are registered copies of the inputs.
- o_load_vld is registered as i_load_vld && !hit, so a consumed beat is removed from the chain.
- o_wgt_rdy sets on the hit that wraps load_ptr to 0 and stays set until reset. When WGT_DEPTH=1, it sets on the first hit.

**Compute path**
- On i_pop_vld, the operation uses wgt[pop_ptr], then pop_ptr increments with the same wrap rule.
- Pipeline:
  - S1 registers left, up, the selected weight and the valid bit.
  - S2 registers the 2*IN_DATA_WIDTH signed product and the delayed up value.
  - S3 computes product (sign-extended) + up into o_down_data.
- A stage loads only when its valid bit is 1. Otherwise it holds, so o_down_data holds its last result.
- The valid bit shifts every cycle.
- A pop before any load uses reset weights of 0, so o_down_data = i_up_data.
- Simultaneous hit and pop on the same slot: the pop reads the old weight (read-before-write).

**Pass-through**
- o_right_data <= i_left_data every cycle, independent of pops.

**Arithmetic**
- Sum wraps modulo 2^OUT_DATA_WIDTH unless saturation is compiled in (see Configuration).

## Timing
- Reset value of every output, pointer, weight and pipeline register: 0.
- Reset assertion clears everything immediately, including in-flight pops; no stale o_pop_vld after release.
- Load forward latency: 1 cycle.
- Right forward latency: 1 cycle.
- Pop-to-down latency: 3 cycles. A pop at cycle t drives o_pop_vld=1 and the valid o_down_data at t+3.
- Full throughput: one pop per cycle, no stalls, no backpressure.
- Loads and pops are fully concurrent.

## Configuration
- Macro: PE_MSLOT_SAT_EN.
- Defined: the S3 sum saturates to [-2^(OUT_DATA_WIDTH-1), 2^(OUT_DATA_WIDTH-1)-1].
- Undefined: the S3 sum wraps two's complement.
- Latency is identical either way.

## Test plan
All scenarios use ID_VAL=3, WGT_DEPTH=4, IN=8, OUT=24 unless stated.
- **Load chain:** beats (id,data) = (3,10),(5,20),(3,-3),(3,7),(3,2) on consecutive cycles.
  - One cycle later, o_load_vld is 0,1,0,0,0 and o_load_id/o_load_data mirror the inputs.
  - Bank = {10,-3,7,2}.
  - o_wgt_rdy rises the cycle after the 4th hit.
- **Pop rotation:** bank from the previous scenario; left=5, up=100; five pops at t..t+4.
  - o_down_data = 150, 85, 135, 110, 150 at t+3..t+7, with o_pop_vld high for exactly those cycles.
  - After the last result, o_down_data holds at 150.
- **Read-before-write:** pop slot 0 (wgt=10) and hit with data 9 in the same cycle; left=1, up=0.
  - Result is 10.
  - The next pop of slot 0 yields 9.
- **Overflow (OUT=16):** left=-128, wgt=-128, up=32767.
  - Without the macro, result is -16385.
  - With PE_MSLOT_SAT_EN, result is 32767.
- **Reset mid-run:** drop rst_n with 3 pops in flight.
  - All outputs read 0 immediately.
  - After release with no new pops, o_pop_vld stays 0.
  - Pointers restart at slot 0.
  - o_wgt_rdy=0.
- **Right pass-through:** left = 1,2,3 with i_pop_vld=0.
  - o_right_data = 1,2,3 one cycle later.
  - o_down_data unchanged.
